// File: rtl/bt_uart_pkg.sv
// Shared types and defaults for the Bluetooth UART receiver.
// Holds the receiver FSM state encoding.
package bt_uart_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/bt_byte_fifo.sv
// Small receive byte buffer with valid/ready read side.
// A write into a full buffer is dropped unless a pop frees a slot.
module bt_byte_fifo
  import bt_uart_pkg::*;
#(
  parameter int W     = DATA_BITS_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   wr_valid,
  input  logic [W-1:0]           wr_data,
  output logic                   drop,
  output logic [W-1:0]           rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          push;

  assign full     = count == ($clog2(DEPTH)+1)'(DEPTH);
  assign rd_valid = count != '0;
  assign rd_data  = mem[rd_ptr];
  assign pop      = rd_valid && rd_ready;
  assign drop     = wr_valid && full && !pop;
  assign push     = wr_valid && !drop;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/bt_uart_rx.sv
// 8N1-style UART receiver for the Bluetooth module link.
// Mid-bit sampling with runtime clocks-per-bit, sticky error flags.
module bt_uart_rx
  import bt_uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CPD_W      = 10
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        fpga_rxd,
  input  logic [CPD_W-1:0]            uart_cpd,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        framing_error,
  output logic                        overrun,
  input  logic                        clear_errors
);

  localparam int BW = $clog2(DATA_BITS + 1);

  logic                 rst_q;
  logic                 rst_n_s;
  logic                 rxd_m;
  logic                 rxd_s;
  rx_state_e            state;
  logic [CPD_W-1:0]     cpd;
  logic [CPD_W-1:0]     cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 tick;
  logic                 push;
  logic                 drop;

  // Assert asynchronously, release only on a clock edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) {rst_n_s, rst_q} <= 2'b00;
    else         {rst_n_s, rst_q} <= {rst_q, 1'b1};
  end

  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) {rxd_s, rxd_m} <= 2'b11;
    else          {rxd_s, rxd_m} <= {rxd_m, fpga_rxd};
  end

  assign tick = cnt == cpd - 1'b1;
  assign push = (state == STOP) && tick && rxd_s;

  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state         <= IDLE;
      cpd           <= CPD_W'(2);
      cnt           <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      framing_error <= 1'b0;
    end else begin
      if (clear_errors) framing_error <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          cpd     <= (uart_cpd < CPD_W'(2)) ? CPD_W'(2) : uart_cpd;
          if (!rxd_s) state <= START;
        end
        START: begin
          if (cnt == (cpd >> 1)) begin
            cnt   <= '0;
            state <= rxd_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            cnt     <= '0;
            shift   <= {rxd_s, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(DATA_BITS - 1)) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            cnt <= '0;
            if (rxd_s) begin
              state <= IDLE;
            end else begin
              framing_error <= 1'b1;
              state         <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: if (rxd_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s)          overrun <= 1'b0;
    else if (drop)         overrun <= 1'b1;
    else if (clear_errors) overrun <= 1'b0;
  end

  bt_byte_fifo #(
    .W     (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .resetn   (rst_n_s),
    .wr_valid (push),
    .wr_data  (shift),
    .drop     (drop),
    .rd_data  (rx_data),
    .rd_valid (rx_valid),
    .rd_ready (rx_ready),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_bt_uart_rx.sv
// Bench for bt_uart_rx: directed frames plus randomized traffic
// checked every cycle against a frame-level queue model.
module tb_bt_uart_rx;

  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int CPD_W = 10;

  logic                    clock = 1'b0;
  logic                    resetn = 1'b1;
  logic                    fpga_rxd = 1'b1;
  logic [CPD_W-1:0]        uart_cpd = 10'd10;
  logic [DB-1:0]           rx_data;
  logic                    rx_valid;
  logic                    rx_ready = 1'b0;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    framing_error;
  logic                    overrun;
  logic                    clear_errors = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint     at;
    logic [7:0] data;
    bit         ok;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] mq[$];
  bit         m_fe = 0;
  bit         m_ov = 0;
  bit         rand_en = 0;
  bit         cmp_en = 0;
  longint     ready_at = -1;

  bt_uart_rx #(
    .DATA_BITS  (DB),
    .FIFO_DEPTH (DEPTH),
    .CPD_W      (CPD_W)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .fpga_rxd      (fpga_rxd),
    .uart_cpd      (uart_cpd),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .fifo_count    (fifo_count),
    .framing_error (framing_error),
    .overrun       (overrun),
    .clear_errors  (clear_errors)
  );

  always #5 clock = ~clock;

  // Index of the most recent rising edge (edges at 5, 15, 25, ...).
  function automatic longint edge_now();
    return (longint'($time) - 5) / 10;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Frame-level model: each frame lands at a precomputed edge.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      evq.delete();
      mq.delete();
      m_fe = 0;
      m_ov = 0;
    end else begin : step
      longint     e;
      bit         pop;
      bit         hit;
      bit         push;
      bit         drop;
      logic [7:0] d;
      e    = edge_now();
      pop  = (mq.size() != 0) && rx_ready;
      hit  = (evq.size() != 0) && (evq[0].at == e);
      push = hit && evq[0].ok;
      d    = hit ? evq[0].data : 8'h00;
      drop = push && (mq.size() == DEPTH) && !pop;
      if (pop) void'(mq.pop_front());
      if (push && !drop) mq.push_back(d);
      if (hit && !evq[0].ok) m_fe = 1;
      else if (clear_errors) m_fe = 0;
      if (drop) m_ov = 1;
      else if (clear_errors) m_ov = 0;
      if (hit) void'(evq.pop_front());
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("valid", 32'(rx_valid), 32'(mq.size() != 0));
      chk("count", 32'(fifo_count), 32'(mq.size()));
      chk("framing_error", 32'(framing_error), 32'(m_fe));
      chk("overrun", 32'(overrun), 32'(m_ov));
      if (mq.size() != 0) chk("data", 32'(rx_data), 32'(mq[0]));
    end
  end

  task automatic tick();
    longint nxt;
    nxt = edge_now() + 1;
    if (rand_en) begin
      rx_ready     = ($urandom_range(0, 1) == 1);
      clear_errors = ($urandom_range(0, 31) == 0);
    end
    if (nxt == ready_at) rx_ready = 1'b1;
    else if (!rand_en) rx_ready = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Line falls right after edge k; detection takes 3 edges, the start
  // bit is sampled cpd/2+1 edges later, then one sample per cpd.
  task automatic send_frame(input logic [7:0] d, input bit stop,
                            input int abort_bit, input bit scramble,
                            input bit hold_ready);
    longint           k;
    longint           at;
    int               c;
    logic [9:0]       bits;
    logic [CPD_W-1:0] keep;
    k    = edge_now();
    c    = int'(uart_cpd);
    keep = uart_cpd;
    bits = {stop, d, 1'b0};
    at   = k + 4 + c / 2 + (DB + 1) * c;
    if (abort_bit < 0) evq.push_back('{at: at, data: d, ok: stop});
    if (hold_ready) ready_at = at;
    for (int n = 0; n < 10; n++) begin
      fpga_rxd = bits[n];
      for (int j = 0; j < c; j++) begin
        if (scramble && n == 1 && j == 0)
          uart_cpd = CPD_W'($urandom);
        if (n == abort_bit && j == 0) resetn = 1'b0;
        if (n == abort_bit && j == 2) begin
          chk("rst_valid", 32'(rx_valid), 32'd0);
          chk("rst_count", 32'(fifo_count), 32'd0);
          chk("rst_data", 32'(rx_data), 32'd0);
          chk("rst_ferr", 32'(framing_error), 32'd0);
          chk("rst_ovr", 32'(overrun), 32'd0);
          resetn = 1'b1;
        end
        tick();
      end
    end
    fpga_rxd = 1'b1;
    uart_cpd = keep;
  endtask

  task automatic send(input logic [7:0] d);
    send_frame(d, 1'b1, -1, 1'b0, 1'b0);
  endtask

  task automatic glitch(input int len);
    fpga_rxd = 1'b0;
    repeat (len) tick();
    fpga_rxd = 1'b1;
    idle(int'(uart_cpd) / 2 + 6);
  endtask

  task automatic pop_expect(input logic [7:0] exp);
    chk("pop_valid", 32'(rx_valid), 32'd1);
    chk("pop_data", 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    @(posedge clock);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
  endtask

  initial begin
    #2;
    resetn = 1'b0;
    cmp_en = 1;
    repeat (3) @(posedge clock);
    #1;
    chk("init_valid", 32'(rx_valid), 32'd0);
    chk("init_count", 32'(fifo_count), 32'd0);
    chk("init_data", 32'(rx_data), 32'd0);
    chk("init_ferr", 32'(framing_error), 32'd0);
    chk("init_ovr", 32'(overrun), 32'd0);
    resetn = 1'b1;
    idle(5);

    send(8'hA5);
    idle(6);
    chk("a5_data", 32'(rx_data), 32'hA5);
    chk("a5_valid", 32'(rx_valid), 32'd1);
    chk("a5_count", 32'(fifo_count), 32'd1);
    chk("a5_flags", 32'({framing_error, overrun}), 32'd0);
    pop_expect(8'hA5);

    glitch(3);
    chk("glitch_count", 32'(fifo_count), 32'd0);

    send_frame(8'h3C, 1'b0, -1, 1'b0, 1'b0);
    idle(6);
    chk("fe_set", 32'(framing_error), 32'd1);
    chk("fe_count", 32'(fifo_count), 32'd0);
    send(8'h3C);
    idle(6);
    chk("fe_next_data", 32'(rx_data), 32'h3C);
    chk("fe_next_count", 32'(fifo_count), 32'd1);
    pulse_clear();
    chk("fe_cleared", 32'(framing_error), 32'd0);
    pop_expect(8'h3C);

    for (int i = 1; i <= 5; i++) begin
      send(8'(i));
      idle(4);
    end
    chk("ovr_count", 32'(fifo_count), 32'd4);
    chk("ovr_flag", 32'(overrun), 32'd1);
    for (int i = 1; i <= 4; i++) pop_expect(8'(i));
    chk("ovr_drained", 32'(fifo_count), 32'd0);
    pulse_clear();
    chk("ovr_cleared", 32'(overrun), 32'd0);

    for (int i = 0; i < 4; i++) begin
      send(8'h10 + 8'(i));
      idle(4);
    end
    send_frame(8'h14, 1'b1, -1, 1'b0, 1'b1);
    ready_at = -1;
    idle(4);
    chk("full_pop_count", 32'(fifo_count), 32'd4);
    chk("full_pop_ovr", 32'(overrun), 32'd0);
    for (int i = 1; i <= 4; i++) pop_expect(8'h10 + 8'(i));

    send(8'h77);
    idle(4);
    send_frame(8'h3C, 1'b0, -1, 1'b0, 1'b0);
    idle(6);
    chk("pre_rst_count", 32'(fifo_count), 32'd1);
    chk("pre_rst_ferr", 32'(framing_error), 32'd1);
    send_frame(8'hFF, 1'b1, 5, 1'b0, 1'b0);
    idle(6);
    send(8'h55);
    idle(6);
    chk("post_rst_count", 32'(fifo_count), 32'd1);
    chk("post_rst_data", 32'(rx_data), 32'h55);
    pop_expect(8'h55);

    rand_en = 1;
    for (int it = 0; it < 60; it++) begin
      int r;
      uart_cpd = CPD_W'($urandom_range(6, 20));
      idle(2);
      r = $urandom_range(0, 9);
      if (r == 0)
        glitch($urandom_range(1, int'(uart_cpd) / 2));
      else
        send_frame(8'($urandom), r != 1, -1,
                   $urandom_range(0, 3) == 0, 1'b0);
      idle($urandom_range(4, 10));
    end
    rand_en      = 0;
    clear_errors = 1'b0;
    rx_ready     = 1'b1;
    repeat (DEPTH + 2) begin
      @(posedge clock);
      #1;
    end
    rx_ready = 1'b0;
    chk("final_count", 32'(fifo_count), 32'd0);
    idle(2);
    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/bt_uart_rx.md
BT_UART_RX -- requirements
Module: bt_uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, giving the payload bits per UART frame.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the receive byte buffer depth (power of two).
REQ-003 SHALL have parameter CPD_W, default 10, giving the width of the clocks-per-bit input.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port fpga_rxd, input, 1 bit: raw serial line from the Bluetooth module, asynchronous, idle high.
REQ-007 SHALL have port uart_cpd, input, CPD_W bits: clock cycles per UART bit.
REQ-008 SHALL have port rx_data, output, DATA_BITS bits: FIFO head byte.
REQ-009 SHALL have port rx_valid, output, 1 bit: FIFO not empty.
REQ-010 SHALL have port rx_ready, input, 1 bit: consumer pops the head when rx_valid&&rx_ready.
REQ-011 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: bytes held.
REQ-012 SHALL have port framing_error, output, 1 bit: sticky flag, set when a stop bit is sampled low.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag, set when a byte arrives while the FIFO is full.
REQ-014 SHALL have port clear_errors, input, 1 bit: synchronous clear of both sticky flags.

Function
REQ-015 SHALL pass fpga_rxd through a 2-flop synchroniser; both flops reset to 1.
REQ-016 SHALL latch uart_cpd in IDLE only; a latched value below 2 is treated as 2; mid-frame changes have no effect.
REQ-017 SHALL use FSM states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-018 IDLE -> START on synchronised line = 0; the bit counter clears.
REQ-019 START: at count = cpd>>1, the line is sampled; 0 -> DATA (counter cleared), 1 -> IDLE (glitch rejected, nothing pushed).
REQ-020 DATA: every cpd cycles one bit is sampled, LSB first, into a shift register; after DATA_BITS samples -> STOP.
REQ-021 STOP: after cpd cycles the line is sampled; 1 -> push byte, then IDLE; 0 -> set framing_error, discard byte, then WAIT_HIGH.
REQ-022 WAIT_HIGH -> IDLE on first synchronised line = 1.
REQ-023 SHALL make a pushed byte visible on rx_data/rx_valid exactly one cycle after the stop-sample cycle.
REQ-024 FIFO full, push with no pop: byte dropped, overrun set, FIFO unchanged.
REQ-025 FIFO full, push and pop in the same cycle: both are performed, no overrun, count unchanged.
REQ-026 FIFO empty: rx_ready is ignored; rx_data is don't-care but stable.
REQ-027 SHALL let pointers wrap modulo FIFO_DEPTH; fifo_count saturates at neither end beyond 0..FIFO_DEPTH.
REQ-028 If clear_errors and a new error event coincide, the flag SHALL end set (set wins).

Reset
REQ-029 On resetn low, SHALL asynchronously force: FSM = IDLE, counters = 0, pointers = 0, fifo_count = 0, rx_valid = 0, rx_data = 0, framing_error = 0, overrun = 0, synchroniser = 1.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no push; after release the receiver waits for a fresh falling edge.
REQ-031 SHALL synchronise reset release to clock before use by the FSM.

Structure
REQ-032 SHALL place the FSM state enum and the default DATA_BITS/FIFO_DEPTH constants in the shared package bt_uart_pkg.
REQ-033 SHALL implement the buffer as one sub-module bt_byte_fifo (valid/ready, count output); the FSM and bit timing stay in bt_uart_rx.

Verification
REQ-034 SHALL pass this test: cpd = 10, send 0xA5 (8N1), rx_ready = 0 -> rx_data = 0xA5, rx_valid = 1, fifo_count = 1, flags 0; first visible 1 cycle after the stop sample.
REQ-035 SHALL pass this test: cpd = 10, low pulse of 3 cycles on idle line -> no push, FSM back in IDLE, fifo_count = 0.
REQ-036 SHALL pass this test: cpd = 10, frame 0x3C with stop bit = 0, then line high -> framing_error = 1, fifo_count = 0; next frame 0x3C received normally; clear_errors pulse -> framing_error = 0.
REQ-037 SHALL pass this test: FIFO_DEPTH = 4, rx_ready = 0, send 0x01..0x05 -> fifo_count = 4, overrun = 1; then drain -> 0x01,0x02,0x03,0x04.
REQ-038 SHALL pass this test: FIFO full, rx_ready = 1 held on the cycle a new byte pushes -> count stays 4, overrun = 0, order preserved.
REQ-039 SHALL pass this test: resetn pulsed low during bit 4 of 0xFF -> all outputs at reset values; next full frame 0x55 received correctly.
